// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: load-use, flush, mul/div occupancy, mem wait.
// Optional PIPE_PERF_EN adds stall and flush cycle counters.
module pipe_hazard_ctrl #(
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clk_i,
   input  logic       rst,
   input  logic [4:0] D_rs1_i,
   input  logic [4:0] D_rs2_i,
   input  logic       D_use_rs1_i,
   input  logic       D_use_rs2_i,
   input  logic       DD_is_load_i,
   input  logic       DD_need_dstE_i,
   input  logic [4:0] DD_dstE_i,
   input  logic       E_mispredict_i,
   input  logic       E_long_op_i,
   input  logic       M_mem_busy_i,
   output logic       F_stall_o,
   output logic       D_stall_o,
   output logic       D_bubble_o,
   output logic       DD_stall_o,
   output logic       DD_bubble_o,
   output logic       E_stall_o,
   output logic       E_bubble_o,
   output logic       M_bubble_o,
   output logic       E_busy_o
`ifdef PIPE_PERF_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   localparam bit MD_MULTI = (MULDIV_LAT > 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_LAT - 2);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             luse, start, muldiv_wait, mem_wait, flush;

   assign luse = DD_is_load_i & DD_need_dstE_i & (DD_dstE_i != 5'd0)
               & ((D_use_rs1_i & (D_rs1_i == DD_dstE_i))
               |  (D_use_rs2_i & (D_rs2_i == DD_dstE_i)));

   assign start       = (state == IDLE) & E_long_op_i & MD_MULTI;
   assign muldiv_wait = start | ((state == BUSY) & (cnt != '0));
   // HOLD is only ever entered/kept with memory busy, so memory alone decides
   assign mem_wait    = M_mem_busy_i;
   assign flush       = ~rst & ~mem_wait & ~muldiv_wait & E_mispredict_i;

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = BUSY;
               cnt_nxt   = CNT_INIT;
            end
         end
         BUSY: begin
            if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
            else state_nxt = M_mem_busy_i ? HOLD : IDLE;
         end
         HOLD: begin
            if (!M_mem_busy_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      F_stall_o   = 1'b0;
      D_stall_o   = 1'b0;
      D_bubble_o  = 1'b0;
      DD_stall_o  = 1'b0;
      DD_bubble_o = 1'b0;
      E_stall_o   = 1'b0;
      E_bubble_o  = 1'b0;
      M_bubble_o  = 1'b0;
      E_busy_o    = 1'b0;
      if (!rst) begin
         E_busy_o = muldiv_wait;
         if (mem_wait) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            DD_stall_o = 1'b1;
            E_stall_o  = 1'b1;
            M_bubble_o = 1'b1;
         end else if (muldiv_wait) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            DD_stall_o = 1'b1;
            E_bubble_o = 1'b1;
         end else if (E_mispredict_i) begin
            D_bubble_o  = 1'b1;
            DD_bubble_o = 1'b1;
         end else if (luse) begin
            F_stall_o   = 1'b1;
            D_stall_o   = 1'b1;
            DD_bubble_o = 1'b1;
         end
      end
   end

`ifdef PIPE_PERF_EN
   logic [31:0] stall_q, flush_q;

   always_ff @(posedge clk_i) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_q + {31'd0, F_stall_o};
         flush_q <= flush_q + {31'd0, flush};
      end
   end

   assign stall_cnt_o = rst ? 32'd0 : stall_q;
   assign flush_cnt_o = rst ? 32'd0 : flush_q;
`else
   logic unused_flush;
   assign unused_flush = flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MULDIV_LAT=4).
// Output vector: {F_st,D_st,D_bub,DD_st,DD_bub,E_st,E_bub,M_bub,E_busy}.
module tb_pipe_hazard_ctrl;

   localparam logic [8:0] NONE  = 9'b000000000;
   localparam logic [8:0] LUSE  = 9'b110010000;
   localparam logic [8:0] MUL   = 9'b110100101;
   localparam logic [8:0] MEM   = 9'b110101010;
   localparam logic [8:0] MEMB  = 9'b110101011;
   localparam logic [8:0] FLUSH = 9'b001010000;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1, rs2, dst;
   logic       use1, use2, is_load, need_dst;
   logic       mispred, long_op, mem_busy;
   logic       f_st, d_st, d_bub, dd_st, dd_bub;
   logic       e_st, e_bub, m_bub, e_busy;
   logic [8:0] obs;
   int         errs = 0;
   int         checks = 0;
`ifdef PIPE_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
   logic [31:0] exp_stall = 0;
   logic [31:0] exp_flush = 0;
`endif

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(4)) dut (
      .clk_i(clk), .rst(rst),
      .D_rs1_i(rs1), .D_rs2_i(rs2),
      .D_use_rs1_i(use1), .D_use_rs2_i(use2),
      .DD_is_load_i(is_load), .DD_need_dstE_i(need_dst),
      .DD_dstE_i(dst), .E_mispredict_i(mispred),
      .E_long_op_i(long_op), .M_mem_busy_i(mem_busy),
      .F_stall_o(f_st), .D_stall_o(d_st), .D_bubble_o(d_bub),
      .DD_stall_o(dd_st), .DD_bubble_o(dd_bub),
      .E_stall_o(e_st), .E_bubble_o(e_bub),
      .M_bubble_o(m_bub), .E_busy_o(e_busy)
`ifdef PIPE_PERF_EN
      ,
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
   );

   assign obs = {f_st, d_st, d_bub, dd_st, dd_bub,
                 e_st, e_bub, m_bub, e_busy};

   // Inputs are set right after a negedge; check 2ns later, then advance.
   task automatic step(input string tag, input logic [8:0] exp);
      #2;
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
      end
`ifdef PIPE_PERF_EN
      checks++;
      assert (stall_cnt === (rst ? 32'd0 : exp_stall)) else begin
         errs++;
         $error("FAIL %s_stallcnt obs=%0d exp=%0d",
                tag, stall_cnt, exp_stall);
      end
      checks++;
      assert (flush_cnt === (rst ? 32'd0 : exp_flush)) else begin
         errs++;
         $error("FAIL %s_flushcnt obs=%0d exp=%0d",
                tag, flush_cnt, exp_flush);
      end
      if (rst) begin
         exp_stall = 0;
         exp_flush = 0;
      end else begin
         exp_stall += {31'd0, exp[8]};
         exp_flush += {31'd0, exp[6]};
      end
`endif
      @(negedge clk);
   endtask

   task automatic clr();
      rst = 0; rs1 = 0; rs2 = 0; dst = 0;
      use1 = 0; use2 = 0; is_load = 0; need_dst = 0;
      mispred = 0; long_op = 0; mem_busy = 0;
   endtask

   initial begin
      clr();
      rst = 1; long_op = 1; mem_busy = 1;
      @(negedge clk);
      step("rst_a", NONE);
      step("rst_b", NONE);
      clr();
      step("idle", NONE);

      // load-use on rs1, then cleared
      is_load = 1; need_dst = 1; dst = 5; rs1 = 5; use1 = 1;
      step("luse_rs1", LUSE);
      is_load = 0;
      step("luse_gone", NONE);
      // rd = x0 never hazards
      is_load = 1; dst = 0; rs1 = 0;
      step("luse_x0", NONE);
      // rs2 match only counts when rs2 is used
      dst = 7; rs1 = 3; rs2 = 7; use2 = 0;
      step("rs2_unused", NONE);
      use2 = 1;
      step("luse_rs2", LUSE);
      is_load = 0;
      step("nonload", NONE);
      clr();

      // mul, no memory wait: 3 busy cycles, issues on the 4th
      long_op = 1;
      for (int i = 0; i < 3; i++) step($sformatf("mul_c%0d", i + 1), MUL);
      step("mul_c4", NONE);
      // back in IDLE: a new mul starts immediately
      step("mul2_c1", MUL);
      long_op = 0;
      step("mul2_c2", MUL);
      step("mul2_c3", MUL);
      step("mul2_c4", NONE);

      // mul with memory busy in cycles 2-6
      long_op = 1;
      step("mw_c1", MUL);
      mem_busy = 1;
      step("mw_c2", MEMB);
      step("mw_c3", MEMB);
      step("mw_c4", MEM);
      step("mw_c5", MEM);
      step("mw_c6", MEM);
      mem_busy = 0;
      step("mw_c7", NONE);
      long_op = 0;
      step("mw_c8", NONE);

      // mispredict wins over load-use
      is_load = 1; need_dst = 1; dst = 9; rs1 = 9; use1 = 1;
      mispred = 1;
      step("mp_luse", FLUSH);
      clr();

      // mispredict under memory wait is deferred
      mispred = 1; mem_busy = 1;
      step("mp_mw1", MEM);
      step("mp_mw2", MEM);
      mem_busy = 0;
      step("mp_mw3", FLUSH);
      clr();

      // reset while BUSY with cnt=1
      long_op = 1;
      step("rb_c1", MUL);
      step("rb_c2", MUL);
      rst = 1;
      step("rb_rst", NONE);
      clr();
      step("rb_idle", NONE);
      long_op = 1;
      step("rb_new1", MUL);
      long_op = 0;
      step("rb_new2", MUL);
      step("rb_new3", MUL);
      step("rb_new4", NONE);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
